// File: rtl/multicycle_control_unit_if.sv
// Control-unit side of the shared memory port plus datapath handshake signals.
// The master modport is the control FSM; the slave modport is the datapath/memory side.
interface multicycle_control_unit_if;
    logic        run;
    logic [31:0] instr;
    logic        mem_ready;
    logic        branch_taken;
    logic        mem_req;
    logic        mem_we;
    logic        mem_is_fetch;
    logic [2:0]  mem_op;
    logic        ir_wr;
    logic        pc_wr;
    logic [1:0]  pc_sel;
    logic [1:0]  alu_a_src;
    logic [1:0]  alu_b_src;
    logic [3:0]  alu_ctrl;
    logic [2:0]  branch;
    logic        reg_wr;
    logic [1:0]  wb_sel;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [2:0]  state;

    modport master (
        input  run, instr, mem_ready, branch_taken,
        output mem_req, mem_we, mem_is_fetch, mem_op, ir_wr, pc_wr, pc_sel,
               alu_a_src, alu_b_src, alu_ctrl, branch, reg_wr, wb_sel,
               trap, trap_cause, state
    );

    modport slave (
        output run, instr, mem_ready, branch_taken,
        input  mem_req, mem_we, mem_is_fetch, mem_op, ir_wr, pc_wr, pc_sel,
               alu_a_src, alu_b_src, alu_ctrl, branch, reg_wr, wb_sel,
               trap, trap_cause, state
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM sequencing FETCH/DECODE/EXEC/MEM/WB over one memory port,
// with a memory-timeout watchdog, illegal-instruction trapping and run/halt control.
module multicycle_control_unit #(
    parameter int unsigned TIMEOUT         = 16,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1,
    parameter int unsigned CNT_W           = 8
) (
    input logic                        clk,
    input logic                        rst,
    multicycle_control_unit_if.master  ctrl
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StTrap   = 3'd6
    } state_t;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         cause_q;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    logic       is_load, is_store, is_branch, is_jal, is_jalr, is_alu, is_nop, illegal;
    logic       timed_out;
    logic [3:0] alu_op;
    state_t     next_after;

    logic unused_rs;
    assign unused_rs = ^ctrl.instr[24:15];

    assign opcode     = ctrl.instr[6:0];
    assign f3         = ctrl.instr[14:12];
    assign f7         = ctrl.instr[31:25];
    assign rd         = ctrl.instr[11:7];
    assign timed_out  = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));
    assign next_after = ctrl.run ? StFetch : StIdle;

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        is_alu    = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OpLoad: begin
                is_load = 1'b1;
                illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            OpStore: begin
                is_store = 1'b1;
                illegal  = (f3 > 3'b010);
            end
            OpBranch: begin
                is_branch = 1'b1;
                illegal   = (f3[2:1] == 2'b01);
            end
            OpJal:            is_jal  = 1'b1;
            OpJalr:           is_jalr = 1'b1;
            OpLui, OpAuipc:   is_alu  = 1'b1;
            OpImm: begin
                is_alu = 1'b1;
                if (f3 == 3'b001) illegal = (f7 != 7'b0);
                if (f3 == 3'b101) illegal = (f7 != 7'b0) && (f7 != 7'b0100000);
            end
            OpReg: begin
                is_alu  = 1'b1;
                illegal = !((f7 == 7'b0) ||
                            ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            OpFence, OpSystem: ;
            default:           illegal = 1'b1;
        endcase
        // Illegal encodings that do not trap fall through as NOPs.
        if (illegal) begin
            is_load   = 1'b0;
            is_store  = 1'b0;
            is_branch = 1'b0;
            is_jal    = 1'b0;
            is_jalr   = 1'b0;
            is_alu    = 1'b0;
        end
        is_nop = !(is_load || is_store || is_branch || is_jal || is_jalr || is_alu);
    end

    always_comb begin
        alu_op = 4'b0000;
        if (is_alu && ((opcode == OpReg) || (opcode == OpImm))) begin
            case (f3)
                3'b000:  alu_op = ((opcode == OpReg) && f7[5]) ? 4'b1011 : 4'b0000;
                3'b001:  alu_op = 4'b1000;
                3'b010:  alu_op = 4'b0001;
                3'b011:  alu_op = 4'b0010;
                3'b100:  alu_op = 4'b0011;
                3'b101:  alu_op = f7[5] ? 4'b1010 : 4'b1001;
                3'b110:  alu_op = 4'b0100;
                default: alu_op = 4'b0111;
            endcase
        end else if (is_branch) begin
            alu_op = 4'b1011;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cause_q <= 2'b00;
        end else begin
            cnt_q <= '0;
            case (state_q)
                StIdle: if (ctrl.run) state_q <= StFetch;
                StFetch, StMem: begin
                    if (ctrl.mem_ready) begin
                        if (state_q == StFetch) state_q <= StDecode;
                        else if (is_load)       state_q <= StWb;
                        else                    state_q <= next_after;
                    end else if (timed_out) begin
                        state_q <= StTrap;
                        cause_q <= 2'b10;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StDecode: begin
                    if (illegal && TRAP_ON_ILLEGAL) begin
                        state_q <= StTrap;
                        cause_q <= 2'b01;
                    end else begin
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (is_load || is_store)              state_q <= StMem;
                    else if (is_alu || is_jal || is_jalr) state_q <= StWb;
                    else                                  state_q <= next_after;
                end
                StWb:    state_q <= next_after;
                StTrap:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        ctrl.mem_req      = 1'b0;
        ctrl.mem_we       = 1'b0;
        ctrl.mem_is_fetch = 1'b0;
        ctrl.mem_op       = 3'b000;
        ctrl.ir_wr        = 1'b0;
        ctrl.pc_wr        = 1'b0;
        ctrl.pc_sel       = 2'b00;
        ctrl.alu_a_src    = 2'b00;
        ctrl.alu_b_src    = 2'b00;
        ctrl.alu_ctrl     = 4'b0000;
        ctrl.branch       = 3'b000;
        ctrl.reg_wr       = 1'b0;
        ctrl.wb_sel       = 2'b00;
        ctrl.trap         = 1'b0;
        ctrl.trap_cause   = cause_q;
        ctrl.state        = state_q;

        // ALU selects stay stable through MEM/WB so a combinational address/result holds.
        if ((state_q == StExec) || (state_q == StMem) || (state_q == StWb)) begin
            ctrl.alu_ctrl = alu_op;
            if (opcode == OpLui) begin
                ctrl.alu_a_src = 2'b10;
                ctrl.alu_b_src = 2'b01;
            end else if (opcode == OpAuipc) begin
                ctrl.alu_a_src = 2'b01;
                ctrl.alu_b_src = 2'b01;
            end else if (is_jal || is_jalr) begin
                ctrl.alu_a_src = 2'b01;
                ctrl.alu_b_src = 2'b10;
            end else if ((opcode == OpImm) || is_load || is_store) begin
                ctrl.alu_b_src = 2'b01;
            end
        end

        case (state_q)
            StFetch: begin
                ctrl.mem_req      = 1'b1;
                ctrl.mem_is_fetch = 1'b1;
                ctrl.mem_op       = 3'b010;
                ctrl.ir_wr        = ctrl.mem_ready;
            end
            StExec: begin
                if (is_branch) begin
                    case (f3)
                        3'b000:  ctrl.branch = 3'b000;
                        3'b001:  ctrl.branch = 3'b001;
                        3'b100:  ctrl.branch = 3'b010;
                        3'b101:  ctrl.branch = 3'b011;
                        3'b110:  ctrl.branch = 3'b100;
                        default: ctrl.branch = 3'b101;
                    endcase
                    ctrl.pc_wr  = 1'b1;
                    ctrl.pc_sel = ctrl.branch_taken ? 2'b01 : 2'b00;
                end else if (is_nop) begin
                    ctrl.pc_wr = 1'b1;
                end
            end
            StMem: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = is_store;
                case (f3)
                    3'b000:  ctrl.mem_op = 3'b000;
                    3'b001:  ctrl.mem_op = 3'b001;
                    3'b100:  ctrl.mem_op = 3'b011;
                    3'b101:  ctrl.mem_op = 3'b100;
                    default: ctrl.mem_op = 3'b010;
                endcase
                if (is_load) ctrl.wb_sel = 2'b01;
                if (is_store && ctrl.mem_ready) ctrl.pc_wr = 1'b1;
            end
            StWb: begin
                ctrl.reg_wr = (rd != 5'd0);
                ctrl.pc_wr  = 1'b1;
                if (is_jal) begin
                    ctrl.wb_sel = 2'b10;
                    ctrl.pc_sel = 2'b01;
                end else if (is_jalr) begin
                    ctrl.wb_sel = 2'b10;
                    ctrl.pc_sel = 2'b10;
                end else if (is_load) begin
                    ctrl.wb_sel = 2'b01;
                end
            end
            StTrap: begin
                ctrl.trap   = 1'b1;
                ctrl.pc_wr  = 1'b1;
                ctrl.pc_sel = 2'b11;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: one DUT with a short watchdog that traps on
// illegal encodings, and one that treats illegal encodings as NOPs.
module tb_multicycle_control_unit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    multicycle_control_unit_if ia();
    multicycle_control_unit_if ib();

    multicycle_control_unit #(.TIMEOUT(4), .TRAP_ON_ILLEGAL(1'b1), .CNT_W(8)) u_a (
        .clk  (clk),
        .rst  (rst),
        .ctrl (ia.master)
    );

    multicycle_control_unit #(.TIMEOUT(16), .TRAP_ON_ILLEGAL(1'b0), .CNT_W(8)) u_b (
        .clk  (clk),
        .rst  (rst),
        .ctrl (ib.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the active edge; checks follow 1 unit later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        ia.run = 1'b0; ia.instr = 32'h0; ia.mem_ready = 1'b0; ia.branch_taken = 1'b0;
        ib.run = 1'b0; ib.instr = 32'h0; ib.mem_ready = 1'b0; ib.branch_taken = 1'b0;
        #3;
        chk("rst_state", ia.state, 0);
        chk("rst_strobes", {ia.mem_req, ia.mem_we, ia.ir_wr, ia.pc_wr, ia.reg_wr, ia.trap}, 0);
        chk("rst_selects", {ia.pc_sel, ia.alu_a_src, ia.alu_b_src, ia.wb_sel}, 0);
        chk("rst_cause", ia.trap_cause, 0);
        step();
        rst = 1'b0;

        // ADDI x1,x0,5 with mem_ready on the second fetch cycle
        ia.run = 1'b1; ia.instr = 32'h00500093;
        step(); #1;
        chk("addi_fetch1", {ia.state, ia.mem_req, ia.mem_is_fetch, ia.mem_op, ia.ir_wr},
            {3'd1, 1'b1, 1'b1, 3'b010, 1'b0});
        step(); ia.mem_ready = 1'b1; #1;
        chk("addi_fetch2", {ia.state, ia.ir_wr}, {3'd1, 1'b1});
        step(); ia.mem_ready = 1'b0; #1;
        chk("addi_decode", {ia.state, ia.mem_req, ia.pc_wr, ia.reg_wr}, {3'd2, 3'b000});
        step(); #1;
        chk("addi_exec", {ia.state, ia.alu_ctrl, ia.alu_a_src, ia.alu_b_src, ia.pc_wr},
            {3'd3, 4'b0000, 2'b00, 2'b01, 1'b0});
        step(); #1;
        chk("addi_wb", {ia.state, ia.reg_wr, ia.pc_wr, ia.pc_sel, ia.wb_sel},
            {3'd5, 1'b1, 1'b1, 2'b00, 2'b00});

        // LW x3,0(x1) with mem_ready delayed 3 cycles in MEM
        step(); ia.instr = 32'h0000A183; ia.mem_ready = 1'b1; #1;
        chk("lw_fetch", ia.state, 1);
        step(); ia.mem_ready = 1'b0;
        step(); #1;
        chk("lw_exec", {ia.state, ia.alu_b_src, ia.alu_ctrl}, {3'd3, 2'b01, 4'b0000});
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            chk("lw_mem_wait", {ia.state, ia.mem_req, ia.mem_is_fetch, ia.mem_we, ia.mem_op},
                {3'd4, 1'b1, 1'b0, 1'b0, 3'b010});
        end
        step(); ia.mem_ready = 1'b1; #1;
        chk("lw_mem_done", {ia.state, ia.mem_req, ia.wb_sel, ia.pc_wr}, {3'd4, 1'b1, 2'b01, 1'b0});
        step(); ia.mem_ready = 1'b0; #1;
        chk("lw_wb", {ia.state, ia.wb_sel, ia.reg_wr, ia.pc_sel}, {3'd5, 2'b01, 1'b1, 2'b00});

        // SB x2,0(x1): store completes from MEM straight to FETCH
        step(); ia.instr = 32'h00208023; ia.mem_ready = 1'b1;
        step(); ia.mem_ready = 1'b0;
        step(); #1;
        chk("sb_exec", {ia.state, ia.alu_b_src}, {3'd3, 2'b01});
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            chk("sb_mem_wait", {ia.state, ia.mem_req, ia.mem_we, ia.mem_op, ia.pc_wr},
                {3'd4, 1'b1, 1'b1, 3'b000, 1'b0});
        end
        step(); ia.mem_ready = 1'b1; #1;
        chk("sb_mem_done", {ia.mem_req, ia.mem_we, ia.pc_wr, ia.pc_sel, ia.reg_wr},
            {1'b1, 1'b1, 1'b1, 2'b00, 1'b0});
        step(); #1;
        chk("sb_no_wb", ia.state, 1);

        // BLTU x1,x2,+8 taken, then not taken
        ia.instr = 32'h0020E463;
        step(); ia.mem_ready = 1'b0;
        step(); ia.branch_taken = 1'b1; #1;
        chk("bltu_t_exec", {ia.state, ia.branch, ia.alu_ctrl, ia.alu_a_src, ia.alu_b_src},
            {3'd3, 3'b100, 4'b1011, 2'b00, 2'b00});
        chk("bltu_t_pc", {ia.pc_wr, ia.pc_sel, ia.reg_wr}, {1'b1, 2'b01, 1'b0});
        step(); ia.mem_ready = 1'b1; #1;
        chk("bltu_t_next", ia.state, 1);
        step(); ia.mem_ready = 1'b0;
        step(); ia.branch_taken = 1'b0; ia.run = 1'b0; #1;
        chk("bltu_nt_pc", {ia.state, ia.pc_wr, ia.pc_sel, ia.reg_wr}, {3'd3, 1'b1, 2'b00, 1'b0});
        step(); #1;
        chk("bltu_nt_idle", ia.state, 0);

        // JALR x1,8(x2)
        ia.run = 1'b1; ia.instr = 32'h008100E7;
        step(); ia.run = 1'b0; ia.mem_ready = 1'b1;
        step(); ia.mem_ready = 1'b0;
        step(); #1;
        chk("jalr_exec", {ia.state, ia.alu_a_src, ia.alu_b_src, ia.alu_ctrl},
            {3'd3, 2'b01, 2'b10, 4'b0000});
        step(); #1;
        chk("jalr_wb", {ia.state, ia.wb_sel, ia.pc_sel, ia.reg_wr, ia.pc_wr},
            {3'd5, 2'b10, 2'b10, 1'b1, 1'b1});
        step(); #1;
        chk("jalr_idle", ia.state, 0);

        // Fetch timeout with TIMEOUT=4: five request cycles, then TRAP
        ia.run = 1'b1;
        step(); ia.run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("to_fetch_wait", {ia.state, ia.mem_req, ia.trap}, {3'd1, 1'b1, 1'b0});
            step();
        end
        #1;
        chk("to_trap", {ia.state, ia.trap, ia.trap_cause, ia.pc_sel, ia.pc_wr},
            {3'd6, 1'b1, 2'b10, 2'b11, 1'b1});
        chk("to_trap_quiet", {ia.mem_req, ia.mem_we, ia.reg_wr}, 0);
        step(); #1;
        chk("to_idle", {ia.state, ia.trap, ia.trap_cause}, {3'd0, 1'b0, 2'b10});

        // mem_ready exactly when the counter reaches 4 wins (FENCE, handled as NOP)
        ia.run = 1'b1; ia.instr = 32'h0000000F;
        step(); ia.run = 1'b0;
        for (int i = 0; i < 4; i++) step();
        ia.mem_ready = 1'b1; #1;
        chk("to_edge_ready", {ia.state, ia.ir_wr, ia.mem_req}, {3'd1, 1'b1, 1'b1});
        step(); ia.mem_ready = 1'b0; #1;
        chk("to_edge_decode", {ia.state, ia.trap}, {3'd2, 1'b0});
        step(); #1;
        chk("fence_exec", {ia.state, ia.pc_wr, ia.pc_sel, ia.reg_wr, ia.mem_req},
            {3'd3, 1'b1, 2'b00, 1'b0, 1'b0});
        step(); #1;
        chk("fence_idle", ia.state, 0);

        // Illegal opcode 0x7F traps with cause 01
        ia.run = 1'b1; ia.instr = 32'h0000007F;
        step(); ia.run = 1'b0; ia.mem_ready = 1'b1;
        step(); ia.mem_ready = 1'b0;
        step(); #1;
        chk("ill_trap", {ia.state, ia.trap, ia.trap_cause, ia.reg_wr}, {3'd6, 1'b1, 2'b01, 1'b0});
        step(); #1;
        chk("ill_idle", {ia.state, ia.trap_cause}, {3'd0, 2'b01});

        // Illegal opcode as NOP when trapping is disabled
        ib.run = 1'b1; ib.instr = 32'h0000007F;
        step(); ib.run = 1'b0; ib.mem_ready = 1'b1;
        step(); ib.mem_ready = 1'b0;
        step(); #1;
        chk("nop_ill_exec", {ib.state, ib.pc_wr, ib.pc_sel, ib.reg_wr, ib.mem_req, ib.trap},
            {3'd3, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0});
        step(); #1;
        chk("nop_ill_idle", {ib.state, ib.trap_cause}, {3'd0, 2'b00});

        // Asynchronous reset in the middle of a MEM request
        ia.run = 1'b1; ia.instr = 32'h0000A183;
        step(); ia.run = 1'b0; ia.mem_ready = 1'b1;
        step(); ia.mem_ready = 1'b0;
        step();
        step(); #1;
        chk("rst_pre_mem", {ia.state, ia.mem_req}, {3'd4, 1'b1});
        rst = 1'b1; #1;
        chk("rst_async", {ia.state, ia.mem_req, ia.trap_cause}, {3'd0, 1'b0, 2'b00});
        step();
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle RV32I control FSM; the next generation of the single-cycle decoder.
- Sequences FETCH/DECODE/EXEC/MEM/WB over a single shared memory port with a req/ready handshake.
- Adds a memory-timeout watchdog, illegal-instruction trapping and run/halt control.
- Sits between the IR/PC/regfile/ALU datapath and the unified memory interface.

Parameters:
- TIMEOUT, 16: max wait cycles for mem_ready per request; 0 disables the watchdog.
- TRAP_ON_ILLEGAL, 1: 1 = illegal encoding enters TRAP; 0 = treated as NOP (PC+4, no writes).
- CNT_W, 8: width of the timeout counter; must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- run  in  1  permits starting the next fetch.
- instr  in  32  IR contents; valid from DECODE onward.
- mem_ready  in  1  memory completes the current request this cycle.
- branch_taken  in  1  branch-condition result from the datapath, valid in EXEC.
- mem_req  out  1  memory request.
- mem_we  out  1  write strobe, qualified by mem_req.
- mem_is_fetch  out  1  1 = address is PC; 0 = address is ALU result.
- mem_op  out  3  access size: 000 B, 001 H, 010 W, 011 BU, 100 HU.
- ir_wr  out  1  load IR from memory data.
- pc_wr  out  1  update PC.
- pc_sel  out  2  00 PC+4, 01 PC+imm, 10 (rs1+imm)&~1, 11 trap vector.
- alu_a_src  out  2  00 rs1, 01 PC, 10 zero.
- alu_b_src  out  2  00 rs2, 01 imm, 10 constant 4.
- alu_ctrl  out  4  ADD 0000, SLT 0001, SLTU 0010, XOR 0011, OR 0100, AND 0111, SLL 1000, SRL 1001, SRA 1010, SUB 1011.
- branch  out  3  BEQ 000, BNE 001, BLT 010, BGE 011, BLTU 100, BGEU 101.
- reg_wr  out  1  register-file write enable.
- wb_sel  out  2  00 ALU, 01 memory, 10 PC+4.
- trap  out  1  high for the single TRAP cycle.
- trap_cause  out  2  01 illegal, 10 memory timeout; holds until the next trap.
- state  out  3  IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, TRAP 6.

Behaviour:
- Reset: state = IDLE, timeout counter = 0, trap_cause = 00. All strobes (mem_req, mem_we, ir_wr, pc_wr, reg_wr, trap) are 0; all selects are 0. Reset mid-request drops mem_req asynchronously.
- Outputs are decoded combinationally from the state register and instr. Only state, counter and trap_cause are registered.
- Strobes are 0 in any state or cycle not listed below.
- IDLE: if run, go to FETCH the next cycle.
- FETCH: mem_req = 1, mem_is_fetch = 1, mem_op = 010. mem_req stays high until mem_ready. On mem_ready: ir_wr = 1 in that cycle, then DECODE.
- DECODE: no strobes. Illegal encoding with TRAP_ON_ILLEGAL = 1 goes to TRAP; otherwise EXEC.
- Illegal encodings:
  - unknown opcode;
  - load funct3 011/110/111;
  - store funct3 > 010;
  - branch funct3 010/011;
  - R-type funct7 other than 0000000, or 0100000 with funct3 000/101;
  - SLLI funct7 ≠ 0; SRLI/SRAI funct7 not 0000000/0100000.
- FENCE (0001111) and SYSTEM (1110011) are NOPs.
- EXEC, ALU source selection:
  - LUI: A = zero, B = imm.
  - AUIPC: A = PC, B = imm.
  - OP: rs1, rs2.
  - OP-IMM, load, store: rs1, imm.
  - Branch: rs1, rs2 with SUB.
  - JAL/JALR: A = PC, B = 4.
- EXEC, ALU operation: SLTI → 0001, SLTIU → 0010. Loads, stores, LUI, AUIPC and jumps use ADD.
- EXEC, next state:
  - load/store → MEM;
  - ALU-class and jumps → WB;
  - branch: pc_wr = 1, pc_sel = branch_taken ? 01 : 00, then FETCH if run else IDLE;
  - NOP: pc_wr = 1, pc_sel = 00, same FETCH/IDLE rule.
- MEM: mem_req = 1, mem_is_fetch = 0, mem_we = store, mem_op from funct3 (LBU→011, LHU→100). On mem_ready:
  - load → WB with wb_sel = 01;
  - store → pc_wr = 1, pc_sel = 00, then FETCH or IDLE.
- WB: reg_wr = 1 (suppressed when rd = 0), pc_wr = 1.
  - JAL: wb_sel = 10, pc_sel = 01.
  - JALR: wb_sel = 10, pc_sel = 10.
  - Others: pc_sel = 00.
  - Then FETCH if run else IDLE.
- Timeout counter:
  - Clears on entry to FETCH/MEM and on mem_ready; increments each cycle mem_req = 1 && !mem_ready.
  - When the counter reaches TIMEOUT without mem_ready: mem_req drops, trap_cause = 10, go to TRAP.
  - mem_ready in the same cycle the counter reaches TIMEOUT wins; the request completes normally.
- TRAP: trap = 1, pc_wr = 1, pc_sel = 11, no reg/mem writes, then IDLE.
- run deasserted mid-instruction: the current instruction completes; the FSM stops in IDLE.

Test Plan:
- ADDI x1,x0,5 (0x00500093), mem_ready on 2nd FETCH cycle → FETCH(2)/DECODE/EXEC/WB; alu_ctrl = 0000, alu_b_src = 01, reg_wr = 1, pc_sel = 00 in WB. 5 cycles total.
- LW then SB with mem_ready delayed 3 cycles in MEM → mem_req held 4 cycles. LW: mem_op = 010, wb_sel = 01. SB: mem_we = 1, mem_op = 000, no WB state.
- BLTU taken (funct3 110, branch_taken = 1) → branch = 100, alu_ctrl = 1011, pc_sel = 01, pc_wr in EXEC, reg_wr never high. Repeat with branch_taken = 0 → pc_sel = 00.
- JALR x1,8(x2) → alu_a_src = 01, alu_b_src = 10, WB has wb_sel = 10 and pc_sel = 10.
- TIMEOUT = 4, mem_ready never asserted in FETCH → trap = 1 on the cycle after the counter reaches 4, trap_cause = 10, pc_sel = 11, then IDLE. Repeat with mem_ready exactly at count 4 → no trap.
- Opcode 0x7F → TRAP, trap_cause = 01. With TRAP_ON_ILLEGAL = 0 → PC+4 with no writes. Assert rst mid-MEM → state = 0 and mem_req = 0 immediately.
